fetch_ctrl: RTL and testbench

Fetch-stage sequencer for the RV32 front end. Drives the PC register's `stall`/`redirect_valid`/`redirect_pc` controls and arbitrates the three redirect sources: trap, EX branch and ID jump. It runs a single-outstanding instruction-memory request handshake and presents the fetched instruction to IF/ID through a one-entry output holding register. Sits between the PC register, the instruction-memory port and the decode stage.

---
 rtl/fetch_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer for the RV32 front end.
// Arbitrates trap / EX / ID redirects onto the PC register controls, runs a
// single-outstanding instruction-memory request and presents the fetched
// instruction to IF/ID from a one-entry holding register.
//
// Optional feature: define FETCH_TIMEOUT_EN to add the bus timeout counter and
// the FAULT state (timeout length set by BUS_TIMEOUT). Without it, WAIT waits
// indefinitely and fetch_fault is tied to 0.
//
// Handshakes:
//   imem_req/imem_gnt form a valid/ready pair: a request transfers on a cycle
//   where both are high, and imem_addr is meaningful while imem_req is high.
//   imem_rvalid qualifies imem_rdata for exactly one cycle with no
//   backpressure and is only honoured in WAIT. if_valid has no ready of its
//   own: decode_stall is its inverse, so the presented instruction is consumed
//   on a cycle with if_valid & !decode_stall and no redirect. On a redirect
//   cycle if_valid may still be high and IF/ID must qualify it with the
//   redirect.
//
// dbg_state exposes the FSM state for observation.

module fetch_ctrl #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    input  logic        ex_redirect_valid,
    input  logic [31:0] ex_redirect_pc,
    input  logic        id_redirect_valid,
    input  logic [31:0] id_redirect_pc,
    input  logic        decode_stall,
    input  logic [31:0] pc_in,
    output logic        pc_stall,
    output logic        pc_redirect_valid,
    output logic [31:0] pc_redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        fetch_fault,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3
`ifdef FETCH_TIMEOUT_EN
        ,
        S_FAULT = 3'd4
`endif
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        drop;
    logic        drop_nxt;
    logic        latch_pc;
    logic        latch_instr;
    logic        redir;
    logic [31:0] redir_pc;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(BUS_TIMEOUT + 1);
    localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    logic             timeout_hit;

    assign wait_cnt_nxt = wait_cnt + CNT_W'(1);
    assign timeout_hit  = (wait_cnt_nxt == CNT_W'(BUS_TIMEOUT));
`else
    logic unused_cfg;

    // The timeout length only matters when the timeout logic is built.
    assign unused_cfg = ^BUS_TIMEOUT;
`endif

    // Redirect arbitration: trap beats EX beats ID; targets pass through untouched.
    always_comb begin
        redir = trap_valid | ex_redirect_valid | id_redirect_valid;
        if (trap_valid) begin
            redir_pc = trap_pc;
        end else if (ex_redirect_valid) begin
            redir_pc = ex_redirect_pc;
        end else if (id_redirect_valid) begin
            redir_pc = id_redirect_pc;
        end else begin
            redir_pc = 32'h0;
        end
    end

    assign pc_redirect_pc = redir_pc;
    assign imem_addr      = pc_in;
    assign dbg_state      = state;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state control outputs.
    always_comb begin
        state_nxt         = state;
        drop_nxt          = drop;
        latch_pc          = 1'b0;
        latch_instr       = 1'b0;
        pc_stall          = 1'b1;
        pc_redirect_valid = 1'b0;
        imem_req          = 1'b0;
        if_valid          = 1'b0;

        case (state)
            S_IDLE: begin
                // Redirects are not accepted here; just start fetching.
                state_nxt = S_REQ;
            end

            S_REQ: begin
                pc_redirect_valid = redir;
                pc_stall          = !redir;
                imem_req          = !redir;
                if (imem_gnt && !redir) begin
                    latch_pc  = 1'b1;
                    drop_nxt  = 1'b0;
                    state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                pc_redirect_valid = redir;
                pc_stall          = !redir;
                if (imem_rvalid) begin
                    drop_nxt = 1'b0;
                    if (drop || redir) begin
                        // Response belongs to a flushed path.
                        state_nxt = S_REQ;
                    end else begin
                        latch_instr = 1'b1;
                        state_nxt   = S_HOLD;
                    end
                end else begin
                    if (redir) begin
                        drop_nxt = 1'b1;
                    end
`ifdef FETCH_TIMEOUT_EN
                    if (timeout_hit) begin
                        drop_nxt  = 1'b0;
                        state_nxt = S_FAULT;
                    end
`endif
                end
            end

            S_HOLD: begin
                if_valid          = 1'b1;
                pc_redirect_valid = redir;
                // Sequential advance only when the instruction is consumed.
                pc_stall          = decode_stall && !redir;
                if (redir || !decode_stall) begin
                    state_nxt = S_REQ;
                end
            end

`ifdef FETCH_TIMEOUT_EN
            S_FAULT: begin
                pc_redirect_valid = redir;
                pc_stall          = !redir;
                if (redir) begin
                    state_nxt = S_REQ;
                end
            end
`endif

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Drop flag and the IF/ID holding register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop     <= 1'b0;
            if_pc    <= 32'h0;
            if_instr <= 32'h0;
        end else begin
            drop <= drop_nxt;
            if (latch_pc) begin
                if_pc <= pc_in;
            end
            if (latch_instr) begin
                if_instr <= imem_rdata;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // WAIT-cycle counter; held at zero outside WAIT so it starts clean on entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state != S_WAIT) begin
            wait_cnt <= '0;
        end else if (!imem_rvalid) begin
            wait_cnt <= wait_cnt_nxt;
        end
    end

    assign fetch_fault = (state == S_FAULT);
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed sequences, a redirect arbitration table and a
// randomized run against a transaction-level model of the fetch stage.

module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic        ex_redirect_valid;
    logic [31:0] ex_redirect_pc;
    logic        id_redirect_valid;
    logic [31:0] id_redirect_pc;
    logic        decode_stall;
    logic [31:0] pc_in;
    logic        pc_stall;
    logic        pc_redirect_valid;
    logic [31:0] pc_redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        fetch_fault;
    logic [2:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q[$];

    typedef struct {
        logic        tv;
        logic [31:0] tp;
        logic        ev;
        logic [31:0] ep;
        logic        iv;
        logic [31:0] ip;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_stall;
        logic        exp_req;
    } arb_vec_t;

    arb_vec_t vecs[7];

    fetch_ctrl #(.BUS_TIMEOUT(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .trap_valid        (trap_valid),
        .trap_pc           (trap_pc),
        .ex_redirect_valid (ex_redirect_valid),
        .ex_redirect_pc    (ex_redirect_pc),
        .id_redirect_valid (id_redirect_valid),
        .id_redirect_pc    (id_redirect_pc),
        .decode_stall      (decode_stall),
        .pc_in             (pc_in),
        .pc_stall          (pc_stall),
        .pc_redirect_valid (pc_redirect_valid),
        .pc_redirect_pc    (pc_redirect_pc),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_gnt          (imem_gnt),
        .imem_rvalid       (imem_rvalid),
        .imem_rdata        (imem_rdata),
        .if_valid          (if_valid),
        .if_pc             (if_pc),
        .if_instr          (if_instr),
        .fetch_fault       (fetch_fault),
        .dbg_state         (dbg_state)
    );

    // Clock and reset-time defaults.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The PC register the block controls.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_in <= 32'h0;
        end else if (pc_redirect_valid) begin
            pc_in <= pc_redirect_pc;
        end else if (!pc_stall) begin
            pc_in <= pc_in + 32'd4;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        trap_valid        = 1'b0;
        trap_pc           = 32'h0;
        ex_redirect_valid = 1'b0;
        ex_redirect_pc    = 32'h0;
        id_redirect_valid = 1'b0;
        id_redirect_pc    = 32'h0;
        decode_stall      = 1'b0;
        imem_gnt          = 1'b0;
        imem_rvalid       = 1'b0;
        imem_rdata        = 32'h0;
    endtask

    // Leaves the caller at a negedge with the block in IDLE.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic        resp_pend;
        logic [31:0] resp_addr;
        logic [31:0] exp_addr;
        logic        mem_busy;
        int          mem_cnt;
        logic [31:0] mem_addr;
        logic        stale;
        logic        redir;
        logic [31:0] exp_rpc;
        logic        present;
        logic        adv_exp;

        vecs[0] = '{1'b0, 32'h1111_1111, 1'b0, 32'h2222_2222, 1'b0, 32'h3333_3333, 1'b0, 32'h0,   1'b1, 1'b1};
        vecs[1] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h300,       1'b1, 32'h300, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'h0,         1'b1, 32'h203,       1'b0, 32'h0,         1'b1, 32'h203, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 32'h0,         1'b1, 32'h200,       1'b1, 32'h300,       1'b1, 32'h200, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 32'h81,        1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h81,  1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h80,        1'b1, 32'h200,       1'b1, 32'h300,       1'b1, 32'h80,  1'b0, 1'b0};
        vecs[6] = '{1'b1, 32'h80,        1'b0, 32'h0,         1'b1, 32'h300,       1'b1, 32'h80,  1'b0, 1'b0};

        // ---- reset values and IDLE behaviour ----
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_pc_stall", pc_stall, 1);
        check("rst_imem_req", imem_req, 0);
        check("rst_redir_valid", pc_redirect_valid, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_if_pc", if_pc, 0);
        check("rst_if_instr", if_instr, 0);
        check("rst_fetch_fault", fetch_fault, 0);
        @(negedge clk);
        rst        = 1'b1;
        trap_valid = 1'b1;
        trap_pc    = 32'h40;
        #1;
        check("idle_ignores_redir", pc_redirect_valid, 0);
        check("idle_pc_stall", pc_stall, 1);
        check("idle_imem_req", imem_req, 0);

        // ---- zero-wait memory, no stalls: one instruction every 3 cycles ----
        resp_pend = 1'b0;
        resp_addr = 32'h0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            idle_inputs();
            imem_gnt    = 1'b1;
            imem_rvalid = resp_pend;
            imem_rdata  = mem_word(resp_addr);
            resp_pend   = 1'b0;
            #1;
            if (imem_req) begin
                resp_pend = 1'b1;
                resp_addr = imem_addr;
            end
            exp_addr = 32'(k / 3) * 32'd4;
            check("zw_req", imem_req, (k % 3) == 0);
            if ((k % 3) == 0) check("zw_addr", imem_addr, exp_addr);
            check("zw_if_valid", if_valid, (k % 3) == 2);
            if ((k % 3) == 2) begin
                check("zw_if_pc", if_pc, exp_addr);
                check("zw_if_instr", if_instr, mem_word(exp_addr));
            end
        end

        // ---- decode_stall held 4 cycles in HOLD ----
        do_reset();
        @(negedge clk);
        imem_gnt = 1'b1;
        #1;
        check("ds_req", imem_req, 1);
        check("ds_addr", imem_addr, 32'h0);
        @(negedge clk);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0013;
        #1;
        check("ds_wait_if_valid", if_valid, 0);
        @(negedge clk);
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        decode_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check("ds_hold_valid", if_valid, 1);
            check("ds_hold_instr", if_instr, 32'h0000_0013);
            check("ds_hold_pc", if_pc, 32'h0);
            check("ds_hold_stall", pc_stall, 1);
            check("ds_hold_pc_in", pc_in, 32'h0);
        end
        @(negedge clk);
        decode_stall = 1'b0;
        #1;
        check("ds_release_stall", pc_stall, 0);
        check("ds_release_valid", if_valid, 1);
        @(negedge clk);
        #1;
        check("ds_next_pc_in", pc_in, 32'h4);
        check("ds_next_req", imem_req, 1);
        check("ds_next_addr", imem_addr, 32'h4);
        check("ds_next_if_valid", if_valid, 0);

        // ---- EX redirect during WAIT, response two cycles later ----
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt          = 1'b0;
        ex_redirect_valid = 1'b1;
        ex_redirect_pc    = 32'h100;
        #1;
        check("wr_redir_valid", pc_redirect_valid, 1);
        check("wr_redir_pc", pc_redirect_pc, 32'h100);
        check("wr_pc_stall", pc_stall, 0);
        @(negedge clk);
        ex_redirect_valid = 1'b0;
        ex_redirect_pc    = 32'h0;
        #1;
        check("wr_wait_req", imem_req, 0);
        check("wr_pc_in", pc_in, 32'h100);
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        #1;
        check("wr_rvalid_if_valid", if_valid, 0);
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        #1;
        check("wr_dropped_if_valid", if_valid, 0);
        check("wr_dropped_instr", if_instr, 32'h0000_0013);
        check("wr_new_req", imem_req, 1);
        check("wr_new_addr", imem_addr, 32'h100);

        // ---- redirect arbitration table (block parked in REQ, no grant) ----
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            trap_valid        = vecs[v].tv;
            trap_pc           = vecs[v].tp;
            ex_redirect_valid = vecs[v].ev;
            ex_redirect_pc    = vecs[v].ep;
            id_redirect_valid = vecs[v].iv;
            id_redirect_pc    = vecs[v].ip;
            #1;
            check("arb_valid", pc_redirect_valid, vecs[v].exp_valid);
            check("arb_pc", pc_redirect_pc, vecs[v].exp_pc);
            check("arb_stall", pc_stall, vecs[v].exp_stall);
            check("arb_req", imem_req, vecs[v].exp_req);
        end

        // ---- reset in WAIT, late response ignored ----
        @(negedge clk);
        idle_inputs();
        imem_gnt = 1'b1;
        #1;
        check("rw_req_addr", imem_addr, 32'h80);
        @(negedge clk);
        imem_gnt = 1'b0;
        #1;
        check("rw_if_pc", if_pc, 32'h80);
        #2;
        rst = 1'b0;
        #1;
        check("rw_rst_if_pc", if_pc, 32'h0);
        check("rw_rst_if_valid", if_valid, 0);
        check("rw_rst_req", imem_req, 0);
        check("rw_rst_pc_in", pc_in, 32'h0);
        @(negedge clk);
        rst         = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0BAD_0BAD;
        #1;
        check("rw_idle_if_valid", if_valid, 0);
        check("rw_idle_req", imem_req, 0);
        @(negedge clk);
        #1;
        check("rw_req_again", imem_req, 1);
        check("rw_req_addr0", imem_addr, 32'h0);
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        #1;
        check("rw_late_if_valid", if_valid, 0);
        check("rw_late_if_instr", if_instr, 32'h0);
        check("rw_still_req", imem_req, 1);

        // ---- bus timeout ----
        do_reset();
        @(negedge clk);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check("tmo_wait_no_fault", fetch_fault, 0);
            @(negedge clk);
        end
`ifdef FETCH_TIMEOUT_EN
        #1;
        check("tmo_fault", fetch_fault, 1);
        check("tmo_fault_req", imem_req, 0);
        check("tmo_fault_stall", pc_stall, 1);
        trap_valid = 1'b1;
        trap_pc    = 32'h80;
        #1;
        check("tmo_trap_valid", pc_redirect_valid, 1);
        check("tmo_trap_pc", pc_redirect_pc, 32'h80);
        check("tmo_trap_stall", pc_stall, 0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("tmo_cleared", fetch_fault, 0);
        check("tmo_req", imem_req, 1);
        check("tmo_addr", imem_addr, 32'h80);
`else
        for (int i = 0; i < 6; i++) begin
            #1;
            check("tmo_off_no_fault", fetch_fault, 0);
            check("tmo_off_waiting", imem_req, 0);
            @(negedge clk);
        end
`endif

        // ---- randomized run against a transaction-level model ----
        do_reset();
        exp_q.delete();
        mem_busy = 1'b0;
        mem_cnt  = 0;
        mem_addr = 32'h0;
        stale    = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            trap_valid        = ($urandom_range(0, 15) == 0);
            trap_pc           = $urandom;
            ex_redirect_valid = ($urandom_range(0, 15) == 0);
            ex_redirect_pc    = $urandom;
            id_redirect_valid = ($urandom_range(0, 15) == 0);
            id_redirect_pc    = $urandom;
            decode_stall      = ($urandom_range(0, 2) == 0);
            if (mem_busy) begin
                mem_cnt--;
                imem_rvalid = (mem_cnt == 0);
                imem_rdata  = (mem_cnt == 0) ? mem_word(mem_addr) : $urandom;
            end else begin
                imem_rvalid = ($urandom_range(0, 9) == 0);
                imem_rdata  = $urandom;
            end
            #1;
            imem_gnt = imem_req ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
            #1;

            redir   = trap_valid | ex_redirect_valid | id_redirect_valid;
            exp_rpc = trap_valid ? trap_pc :
                      ex_redirect_valid ? ex_redirect_pc :
                      id_redirect_valid ? id_redirect_pc : 32'h0;
            present = (exp_q.size() != 0);
            adv_exp = present && !decode_stall && !redir;

            check("rnd_redir_pc", pc_redirect_pc, exp_rpc);
            check("rnd_redir_valid", pc_redirect_valid, redir);
            check("rnd_if_valid", if_valid, present);
            if (present) begin
                check("rnd_if_pc", if_pc, exp_q[0][63:32]);
                check("rnd_if_instr", if_instr, exp_q[0][31:0]);
            end
            check("rnd_req", imem_req, !present && !mem_busy && !redir);
            if (imem_req) check("rnd_addr", imem_addr, pc_in);
            check("rnd_pc_stall", pc_stall, !(adv_exp || redir));
            check("rnd_no_fault", fetch_fault, 0);

            if (present && (redir || !decode_stall)) begin
                void'(exp_q.pop_front());
            end
            if (imem_req && imem_gnt) begin
                mem_busy = 1'b1;
                mem_cnt  = $urandom_range(1, 3);
                mem_addr = imem_addr;
                stale    = 1'b0;
            end else if (mem_busy && imem_rvalid) begin
                if (!(stale || redir)) begin
                    exp_q.push_back({mem_addr, mem_word(mem_addr)});
                end
                mem_busy = 1'b0;
            end else if (mem_busy && redir) begin
                stale = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
